// File: rtl/game_session_controller_if.sv
// Bundle of the session controller's video, button, game-logic and music signals.
// The controller uses the slave view and the surrounding logic uses the master view.
interface game_session_controller_if;
  logic        vsync_in;
  logic        start_btn_in;
  logic        pause_btn_in;
  logic        block_sliced_in;
  logic [11:0] score_in;
  logic [2:0]  state_out;
  logic        game_enable_out;
  logic        start_music_out;
  logic        stop_music_out;
  logic        music_mute_out;
  logic        slice_valid_out;
  logic [15:0] frame_count_out;
  logic [15:0] countdown_left_out;
  logic [11:0] slice_count_out;
  logic [11:0] final_score_out;

  modport master (
    output vsync_in, start_btn_in, pause_btn_in, block_sliced_in, score_in,
    input  state_out, game_enable_out, start_music_out, stop_music_out,
           music_mute_out, slice_valid_out, frame_count_out, countdown_left_out,
           slice_count_out, final_score_out
  );

  modport slave (
    input  vsync_in, start_btn_in, pause_btn_in, block_sliced_in, score_in,
    output state_out, game_enable_out, start_music_out, stop_music_out,
           music_mute_out, slice_valid_out, frame_count_out, countdown_left_out,
           slice_count_out, final_score_out
  );
endinterface

// File: rtl/game_session_controller.sv
// Play-session sequencer: idle, countdown, playing, paused, done.
// Counts song time in video frames, gates slice strobes and latches the final score.
module game_session_controller #(
  parameter int COUNTDOWN_FRAMES = 180,
  parameter int SONG_FRAMES      = 7200
) (
  input logic clk_in,
  input logic rst_in,
  game_session_controller_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_COUNTDOWN = 3'd1,
    ST_PLAYING   = 3'd2,
    ST_PAUSED    = 3'd3,
    ST_DONE      = 3'd4
  } state_t;

  localparam logic [15:0] CD_INIT   = 16'(COUNTDOWN_FRAMES);
  localparam logic [15:0] SONG_LAST = 16'(SONG_FRAMES - 1);
  localparam logic [11:0] SLICE_MAX = 12'hFFF;

  state_t      state_r, state_s;
  logic        vsync_prev_r, start_prev_r, pause_prev_r;
  logic        tick_s, start_edge_s, pause_edge_s;
  logic [15:0] countdown_r, countdown_s;
  logic [15:0] frame_r, frame_s;
  logic [11:0] slice_cnt_r, slice_cnt_s;
  logic [11:0] final_r, final_s;
  logic        start_music_r, start_music_s;
  logic        stop_music_r, stop_music_s;
  logic        enable_r, mute_r;
  logic        slice_valid_r, slice_valid_s;

  assign tick_s       = bus.vsync_in & ~vsync_prev_r;
  assign start_edge_s = bus.start_btn_in & ~start_prev_r;
  assign pause_edge_s = bus.pause_btn_in & ~pause_prev_r;

  // Next-state and next-output decode, following start > song end > tick > pause priority.
  always_comb begin
    state_s       = state_r;
    countdown_s   = countdown_r;
    frame_s       = frame_r;
    slice_cnt_s   = slice_cnt_r;
    final_s       = final_r;
    start_music_s = 1'b0;
    stop_music_s  = 1'b0;
    slice_valid_s = 1'b0;

    if (bus.block_sliced_in && (state_r == ST_PLAYING)) begin
      slice_valid_s = 1'b1;
      if (slice_cnt_r != SLICE_MAX) begin
        slice_cnt_s = slice_cnt_r + 12'd1;
      end else begin
        slice_cnt_s = slice_cnt_r;
      end
    end else begin
      slice_valid_s = 1'b0;
    end

    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start_edge_s) begin
          state_s     = ST_COUNTDOWN;
          countdown_s = CD_INIT;
          frame_s     = 16'd0;
          slice_cnt_s = 12'd0;
          final_s     = 12'd0;
        end else begin
          state_s = state_r;
        end
      end
      ST_COUNTDOWN: begin
        if (start_edge_s) begin
          // Music has not started yet, so an abort here sends no stop pulse.
          state_s     = ST_IDLE;
          countdown_s = 16'd0;
        end else if (tick_s) begin
          if (countdown_r == 16'd1) begin
            state_s       = ST_PLAYING;
            countdown_s   = 16'd0;
            start_music_s = 1'b1;
          end else begin
            countdown_s = countdown_r - 16'd1;
          end
        end else begin
          state_s = state_r;
        end
      end
      ST_PLAYING: begin
        if (start_edge_s) begin
          state_s      = ST_IDLE;
          stop_music_s = 1'b1;
        end else if (tick_s) begin
          frame_s = frame_r + 16'd1;
          if (frame_r == SONG_LAST) begin
            state_s      = ST_DONE;
            final_s      = bus.score_in;
            stop_music_s = 1'b1;
          end else if (pause_edge_s) begin
            state_s = ST_PAUSED;
          end else begin
            state_s = ST_PLAYING;
          end
        end else if (pause_edge_s) begin
          state_s = ST_PAUSED;
        end else begin
          state_s = state_r;
        end
      end
      ST_PAUSED: begin
        if (start_edge_s) begin
          state_s      = ST_IDLE;
          stop_music_s = 1'b1;
        end else if (pause_edge_s) begin
          state_s = ST_PLAYING;
        end else begin
          state_s = state_r;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, counters, edge history and registered outputs.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_r       <= ST_IDLE;
      vsync_prev_r  <= 1'b1;
      start_prev_r  <= 1'b1;
      pause_prev_r  <= 1'b1;
      countdown_r   <= 16'd0;
      frame_r       <= 16'd0;
      slice_cnt_r   <= 12'd0;
      final_r       <= 12'd0;
      start_music_r <= 1'b0;
      stop_music_r  <= 1'b0;
      enable_r      <= 1'b0;
      mute_r        <= 1'b0;
      slice_valid_r <= 1'b0;
    end else begin
      state_r       <= state_s;
      vsync_prev_r  <= bus.vsync_in;
      start_prev_r  <= bus.start_btn_in;
      pause_prev_r  <= bus.pause_btn_in;
      countdown_r   <= countdown_s;
      frame_r       <= frame_s;
      slice_cnt_r   <= slice_cnt_s;
      final_r       <= final_s;
      start_music_r <= start_music_s;
      stop_music_r  <= stop_music_s;
      enable_r      <= (state_s == ST_PLAYING);
      mute_r        <= (state_s == ST_PAUSED);
      slice_valid_r <= slice_valid_s;
    end
  end

  assign bus.state_out          = state_r;
  assign bus.game_enable_out    = enable_r;
  assign bus.start_music_out    = start_music_r;
  assign bus.stop_music_out     = stop_music_r;
  assign bus.music_mute_out     = mute_r;
  assign bus.slice_valid_out    = slice_valid_r;
  assign bus.frame_count_out    = frame_r;
  assign bus.countdown_left_out = countdown_r;
  assign bus.slice_count_out    = slice_cnt_r;
  assign bus.final_score_out    = final_r;

endmodule

// File: tb/tb_game_session_controller.sv
// Directed bench for game_session_controller with COUNTDOWN_FRAMES=3, SONG_FRAMES=5.
// Expected values are hand-computed; each check is an immediate assertion.
module tb_game_session_controller;
  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  game_session_controller_if bus ();

  game_session_controller #(.COUNTDOWN_FRAMES(3), .SONG_FRAMES(5)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus)
  );

  always #8 clk_in = ~clk_in;

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    step();
    bus.vsync_in = 1'b1;
    step();
    bus.vsync_in = 1'b0;
  endtask

  task automatic press_start();
    step();
    bus.start_btn_in = 1'b1;
    step();
    bus.start_btn_in = 1'b0;
  endtask

  task automatic press_pause();
    step();
    bus.pause_btn_in = 1'b1;
    step();
    bus.pause_btn_in = 1'b0;
  endtask

  task automatic tick_and_pause();
    step();
    bus.vsync_in     = 1'b1;
    bus.pause_btn_in = 1'b1;
    step();
    bus.vsync_in     = 1'b0;
    bus.pause_btn_in = 1'b0;
  endtask

  task automatic slice();
    step();
    bus.block_sliced_in = 1'b1;
    step();
    bus.block_sliced_in = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_state"}, 16'(bus.state_out), 16'd0);
    chk({tag, "_enable"}, 16'(bus.game_enable_out), 16'd0);
    chk({tag, "_start_music"}, 16'(bus.start_music_out), 16'd0);
    chk({tag, "_stop_music"}, 16'(bus.stop_music_out), 16'd0);
    chk({tag, "_mute"}, 16'(bus.music_mute_out), 16'd0);
    chk({tag, "_slice_valid"}, 16'(bus.slice_valid_out), 16'd0);
    chk({tag, "_frame"}, bus.frame_count_out, 16'd0);
    chk({tag, "_countdown"}, bus.countdown_left_out, 16'd0);
    chk({tag, "_slice_count"}, 16'(bus.slice_count_out), 16'd0);
    chk({tag, "_final"}, 16'(bus.final_score_out), 16'd0);
  endtask

  initial begin
    bus.vsync_in        = 1'b0;
    bus.start_btn_in    = 1'b0;
    bus.pause_btn_in    = 1'b0;
    bus.block_sliced_in = 1'b0;
    bus.score_in        = 12'h000;

    rst_in = 1'b1;
    step();
    step();
    check_all_zero("reset");
    rst_in = 1'b0;
    step();
    chk("post_reset_state", 16'(bus.state_out), 16'd0);

    // Countdown into play, with one ignored slice during countdown.
    press_start();
    chk("cd_entry_state", 16'(bus.state_out), 16'd1);
    chk("cd_entry_left", bus.countdown_left_out, 16'd3);
    tick();
    chk("cd_tick1_left", bus.countdown_left_out, 16'd2);
    tick();
    chk("cd_tick2_left", bus.countdown_left_out, 16'd1);
    chk("cd_tick2_state", 16'(bus.state_out), 16'd1);
    slice();
    chk("cd_slice_valid", 16'(bus.slice_valid_out), 16'd0);
    chk("cd_slice_count", 16'(bus.slice_count_out), 16'd0);
    tick();
    chk("play_state", 16'(bus.state_out), 16'd2);
    chk("play_left", bus.countdown_left_out, 16'd0);
    chk("play_start_music", 16'(bus.start_music_out), 16'd1);
    chk("play_enable", 16'(bus.game_enable_out), 16'd1);
    chk("play_stop_music", 16'(bus.stop_music_out), 16'd0);
    step();
    chk("start_music_one_cycle", 16'(bus.start_music_out), 16'd0);

    // Three slices while playing.
    for (int i = 0; i < 3; i++) begin
      slice();
      chk("play_slice_valid", 16'(bus.slice_valid_out), 16'd1);
      chk("play_slice_count", 16'(bus.slice_count_out), 16'(i + 1));
      step();
      chk("play_slice_valid_drop", 16'(bus.slice_valid_out), 16'd0);
    end

    // Pause and resume around ignored ticks and an ignored slice.
    tick();
    tick();
    chk("frame_2", bus.frame_count_out, 16'd2);
    press_pause();
    chk("paused_state", 16'(bus.state_out), 16'd3);
    chk("paused_mute", 16'(bus.music_mute_out), 16'd1);
    chk("paused_enable", 16'(bus.game_enable_out), 16'd0);
    slice();
    chk("paused_slice_valid", 16'(bus.slice_valid_out), 16'd0);
    chk("paused_slice_count", 16'(bus.slice_count_out), 16'd3);
    for (int i = 0; i < 4; i++) tick();
    chk("paused_frame_held", bus.frame_count_out, 16'd2);
    chk("paused_state_held", 16'(bus.state_out), 16'd3);
    press_pause();
    chk("resume_state", 16'(bus.state_out), 16'd2);
    chk("resume_mute", 16'(bus.music_mute_out), 16'd0);
    chk("resume_enable", 16'(bus.game_enable_out), 16'd1);

    // Tick with pause at a non-final frame: counted, then paused.
    tick_and_pause();
    chk("tp_mid_frame", bus.frame_count_out, 16'd3);
    chk("tp_mid_state", 16'(bus.state_out), 16'd3);
    press_pause();
    chk("tp_resume_state", 16'(bus.state_out), 16'd2);
    tick();
    chk("frame_4", bus.frame_count_out, 16'd4);

    // Final tick together with pause: song end wins.
    bus.score_in = 12'h02A;
    tick_and_pause();
    chk("done_state", 16'(bus.state_out), 16'd4);
    chk("done_frame", bus.frame_count_out, 16'd5);
    chk("done_final", 16'(bus.final_score_out), 16'h02A);
    chk("done_stop_music", 16'(bus.stop_music_out), 16'd1);
    chk("done_start_music", 16'(bus.start_music_out), 16'd0);
    chk("done_enable", 16'(bus.game_enable_out), 16'd0);
    chk("done_mute", 16'(bus.music_mute_out), 16'd0);
    bus.score_in = 12'h055;
    step();
    chk("stop_music_one_cycle", 16'(bus.stop_music_out), 16'd0);
    tick();
    tick();
    press_pause();
    chk("done_hold_state", 16'(bus.state_out), 16'd4);
    chk("done_hold_frame", bus.frame_count_out, 16'd5);
    chk("done_hold_final", 16'(bus.final_score_out), 16'h02A);
    chk("done_hold_slices", 16'(bus.slice_count_out), 16'd3);
    chk("done_hold_stop", 16'(bus.stop_music_out), 16'd0);

    // Restart from DONE clears session counters.
    press_start();
    chk("restart_state", 16'(bus.state_out), 16'd1);
    chk("restart_left", bus.countdown_left_out, 16'd3);
    chk("restart_frame", bus.frame_count_out, 16'd0);
    chk("restart_slices", 16'(bus.slice_count_out), 16'd0);
    chk("restart_final", 16'(bus.final_score_out), 16'd0);
    tick();
    tick();
    tick();
    chk("restart_play", 16'(bus.state_out), 16'd2);

    // Slice counter saturation.
    bus.block_sliced_in = 1'b1;
    for (int i = 0; i < 4100; i++) step();
    bus.block_sliced_in = 1'b0;
    chk("slice_saturate", 16'(bus.slice_count_out), 16'd4095);
    chk("slice_saturate_valid", 16'(bus.slice_valid_out), 16'd1);

    // Abort from PLAYING sends stop and holds the frame count.
    tick();
    chk("abort_pre_frame", bus.frame_count_out, 16'd1);
    press_start();
    chk("abort_play_state", 16'(bus.state_out), 16'd0);
    chk("abort_play_stop", 16'(bus.stop_music_out), 16'd1);
    chk("abort_play_enable", 16'(bus.game_enable_out), 16'd0);
    chk("abort_play_frame", bus.frame_count_out, 16'd1);
    step();
    chk("abort_play_stop_drop", 16'(bus.stop_music_out), 16'd0);

    // Abort from COUNTDOWN sends no stop.
    press_start();
    chk("abort_cd_entry", 16'(bus.state_out), 16'd1);
    press_start();
    chk("abort_cd_state", 16'(bus.state_out), 16'd0);
    chk("abort_cd_stop", 16'(bus.stop_music_out), 16'd0);
    chk("abort_cd_left", bus.countdown_left_out, 16'd0);

    // Start held through reset produces no edge until re-pressed.
    bus.start_btn_in = 1'b1;
    rst_in = 1'b1;
    step();
    step();
    rst_in = 1'b0;
    step();
    step();
    step();
    chk("held_start_state", 16'(bus.state_out), 16'd0);
    bus.start_btn_in = 1'b0;
    step();
    chk("released_start_state", 16'(bus.state_out), 16'd0);
    bus.start_btn_in = 1'b1;
    step();
    bus.start_btn_in = 1'b0;
    chk("repressed_start_state", 16'(bus.state_out), 16'd1);

    // Reset in the middle of play clears everything without a stop pulse.
    tick();
    tick();
    tick();
    tick();
    slice();
    chk("mid_play_frame", bus.frame_count_out, 16'd1);
    chk("mid_play_slices", 16'(bus.slice_count_out), 16'd1);
    rst_in = 1'b1;
    step();
    check_all_zero("mid_play_reset");
    rst_in = 1'b0;
    step();
    chk("mid_play_reset_after", 16'(bus.stop_music_out), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/game_session_controller.md
Name: game_session_controller

Overview:
- Sequences one play session: idle, countdown, playing, optional pause, done.
- Sits between the VGA timing generator, the user buttons, the game-logic/renderer and the music interface.
- Produces the game enable, the music start/stop pulses and the gated slice strobe.
- Keeps the song timer in video frames and latches the final score.

Parameters:
- COUNTDOWN_FRAMES, 180, frames spent in COUNTDOWN before play (3 s at 60 Hz); legal range 1..65535.
- SONG_FRAMES, 7200, frames of active play per session (120 s at 60 Hz); legal range 1..65535.

Ports:
- clk_in  in  1  65 MHz pixel clock.
- rst_in  in  1  synchronous active-high reset.
- vsync_in  in  1  active-high vsync from the VGA generator.
- start_btn_in  in  1  debounced start/abort button level.
- pause_btn_in  in  1  debounced pause button level.
- block_sliced_in  in  1  one-cycle slice pulse from game logic.
- score_in  in  12  live score from game logic.
- state_out  out  3  0=IDLE, 1=COUNTDOWN, 2=PLAYING, 3=PAUSED, 4=DONE.
- game_enable_out  out  1  high only in PLAYING.
- start_music_out  out  1  one-cycle pulse at session start.
- stop_music_out  out  1  one-cycle pulse at song end or abort.
- music_mute_out  out  1  high in PAUSED.
- slice_valid_out  out  1  block_sliced_in gated to PLAYING, one-cycle delayed.
- frame_count_out  out  16  frames elapsed in PLAYING.
- countdown_left_out  out  16  COUNTDOWN_FRAMES minus countdown frames elapsed; 0 outside COUNTDOWN.
- slice_count_out  out  12  slices this session.
- final_score_out  out  12  score latched at song end.

Behaviour:
- Reset applies on clk_in when rst_in=1 and takes priority over all other events. Every output goes to 0 and state goes to IDLE.
- On reset, the three edge-detect history registers (vsync, start, pause) load 1. A level held high through reset therefore produces no edge until it falls and rises again.
- Edge detection:
  - tick = vsync_in & ~vsync_prev.
  - start_edge and pause_edge are formed the same way from their button levels.
  - All three are evaluated in the same cycle the input rises.
- All outputs are registered and update on the cycle of the triggering edge. Observed latency is 1 clock after the input edge.
- Event priority within one cycle: reset > start_edge > end-of-song > tick > pause_edge.
- IDLE:
  - start_edge -> COUNTDOWN.
  - On entry, countdown_left_out=COUNTDOWN_FRAMES and frame_count, slice_count and final_score clear to 0.
- COUNTDOWN:
  - Each tick decrements countdown_left_out.
  - A tick while countdown_left_out==1 -> PLAYING, countdown_left_out=0 and start_music_out=1 for exactly that one cycle.
  - start_edge -> IDLE (abort, no stop pulse because music has not started).
  - pause_edge is ignored.
- PLAYING:
  - game_enable_out=1.
  - Each tick increments frame_count_out.
  - A tick while frame_count_out==SONG_FRAMES-1 -> DONE. In that cycle frame_count_out becomes SONG_FRAMES, final_score_out loads score_in sampled that cycle, and stop_music_out pulses.
  - A tick and pause_edge in the same cycle: the tick is counted, then the state goes to PAUSED. If that tick is the final one, DONE wins and the pause is discarded.
  - start_edge -> IDLE with a stop_music_out pulse. frame_count is held until the next COUNTDOWN entry.
- PAUSED:
  - game_enable_out=0, music_mute_out=1, frame_count held; ticks are ignored.
  - pause_edge -> PLAYING.
  - start_edge -> IDLE with a stop_music_out pulse.
- DONE:
  - Outputs hold, including final_score_out.
  - start_edge -> COUNTDOWN (restart, clears as on IDLE exit).
  - pause_edge is ignored.
- Slices:
  - slice_valid_out(t+1) = block_sliced_in(t) & (state(t)==PLAYING).
  - Each such slice increments slice_count_out, saturating at 4095.
  - A slice arriving on the cycle of PLAYING->DONE still counts, because state(t) is PLAYING.
- Arithmetic: the 16-bit counters never wrap because the parameter ranges bound them. slice_count saturates and never wraps.
- start_music_out and stop_music_out are never high in the same cycle.

Test Plan:
1. COUNTDOWN_FRAMES=3, SONG_FRAMES=5; reset, start_btn rise, 3 vsync rises -> state 0->1->2; countdown_left 3,2,1,0; single start_music pulse on the 3rd tick edge; game_enable=1 from that cycle.
2. Same params, 5 ticks in PLAYING with score_in=0x2A on the final tick -> state=4, frame_count=5, final_score=0x2A, single stop_music pulse; further ticks leave all outputs unchanged.
3. In PLAYING after 2 ticks, pause rise, then 4 ticks, then pause rise -> state 2->3->2, frame_count stays 2 during pause, music_mute high only while paused; game_enable low while paused.
4. Tick and pause rise in the same cycle at frame_count=4 (final) -> DONE, not PAUSED. At frame_count=2 -> frame_count=3 and state PAUSED.
5. Slice pulses: 1 during COUNTDOWN, 3 during PLAYING, 1 during PAUSED -> slice_valid pulses exactly 3 times, each 1 cycle after input, and slice_count=3. Forcing 4100 slices -> slice_count=4095.
6. start_btn held high across reset -> no transition until released and re-pressed. Reset asserted mid-PLAYING -> next cycle state=0, all outputs 0, no stop_music pulse.
